// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: access size codes, FSM states,
// memory-map constants, captured request layout and the fault rule.
package lsu_pkg;

  localparam int RAM_BIT   = 10;   // addr bit selecting RAM (1) vs ROM (0)
  localparam int RAM_WORDS = 256;
  localparam int NUM_LANES = 4;    // byte lanes in a data word
  localparam int VEC_W     = 8;    // bits per lane

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // An access is rejected for a reserved size, a misaligned half/word,
  // or any store aimed at the read-only region.
  function automatic logic req_fault(input logic write, input logic [1:0] size,
                                     input logic [31:0] addr);
    logic f;
    f = 1'b0;
    if (size == SIZE_RSVD)                          f = 1'b1;
    if (size == SIZE_HALF && addr[0])               f = 1'b1;
    if (size == SIZE_WORD && (addr[1:0] != 2'b00))  f = 1'b1;
    if (write && !addr[RAM_BIT])                    f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts/extends load data from a fetched
// word and merges store data into the addressed lane(s) of an old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [NUM_LANES-1:0]            be;
  logic [31:0]                     wrep;
  logic [NUM_LANES-1:0][VEC_W-1:0] old_l, new_l, mrg_l;
  logic [31:0]                     shifted;

  // Byte enables and store data replicated so every lane sees its slice
  always_comb begin
    be   = 4'b1111;
    wrep = wdata;
    case (size)
      SIZE_BYTE: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata;
      end
    endcase
  end

  assign old_l = rword;
  assign new_l = wrep;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign mrg_l[g] = be[g] ? new_l[g] : old_l[g];
  end

  assign mdata = mrg_l;

  // Load: shift the addressed lane(s) down, then zero/sign extend
  always_comb begin
    shifted = rword;
    ldata   = rword;
    case (size)
      SIZE_BYTE: begin
        shifted = rword >> {lane, 3'b000};
        ldata   = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        shifted = rword >> {lane[1], 4'b0000};
        ldata   = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted = rword;
        ldata   = rword;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Loads go ISSUE->WAIT->RESP, word
// stores go straight to WRITE, byte/half stores read-modify-write, and
// rejected accesses skip memory entirely and respond on the next cycle.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  lsu_req_t    req_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        in_fault;
  logic [31:0] ldata, mdata;

  assign accept   = req_valid && req_ready;
  assign in_fault = req_fault(req_write, req_size, req_addr);

  lsu_lane_align u_align (
    .size  (req_q.size),
    .uns   (req_q.uns),
    .lane  (req_q.addr[1:0]),
    .rword (rdata_q),
    .wdata (req_q.wdata),
    .ldata (ldata),
    .mdata (mdata)
  );

  // State register; reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request capture on acceptance, read data capture in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        req_q.write <= req_write;
        req_q.size  <= req_size;
        req_q.uns   <= req_unsigned;
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        fault_q     <= in_fault;
      end
      if (state_q == ST_WAIT) rdata_q <= mem_rdata;
    end
  end

  // Next-state: route by fault / direction / size
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_fault)                               state_d = ST_RESP;
          else if (req_write && req_size == SIZE_WORD) state_d = ST_WRITE;
          else                                        state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = req_q.write ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: everything idles at zero; ready is also held low during reset
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_fault     = 1'b0;
    mem_address    = '0;
    mem_read_write = 1'b0;
    mem_wdata      = '0;
    case (state_q)
      ST_IDLE: req_ready = rst_n;
      ST_ISSUE, ST_WAIT: mem_address = {req_q.addr[31:2], 2'b00};
      ST_WRITE: begin
        mem_address    = {req_q.addr[31:2], 2'b00};
        mem_read_write = 1'b1;
        mem_wdata      = mdata;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        if (!fault_q && !req_q.write) resp_rdata = ldata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a RAM/ROM memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read_write;

  typedef struct { logic fault; logic [31:0] rdata; } exp_t;
  exp_t sb[$];

  logic [31:0] ram [256];
  logic [31:0] shadow [256];
  int checks = 0;
  int fails  = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_address(mem_address),
    .mem_read_write(mem_read_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {8'hC0, a[9:2], ~a[9:2], 8'h5A};
  endfunction

  // memory: combinational read, RAM write on the clock
  assign mem_rdata = mem_address[10] ? ram[mem_address[9:2]] : rom_word(mem_address);
  always @(posedge clk) if (mem_read_write && mem_address[10]) ram[mem_address[9:2]] <= mem_wdata;

  function automatic logic exp_fault(input logic w, input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) || (w && !a[10]);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] wd, input logic [1:0] s,
                                           input logic u, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = wd[8*a[1:0] +: 8];
    h = wd[16*a[1] +: 16];
    if (s == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (s == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return wd;
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [1:0] s,
                                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (s == 2'b00)      r[8*a[1:0] +: 8]  = wd[7:0];
    else if (s == 2'b01) r[16*a[1] +: 16]  = wd[15:0];
    else                 r = wd;
    return r;
  endfunction

  // Response monitor: pop scoreboard on every completion pulse
  always @(negedge clk) begin
    if (mem_read_write) wr_cnt++;
    if (resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_resp: got fault=%0b rdata=%h, none expected", resp_fault, resp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resp_fault !== e.fault || resp_rdata !== e.rdata) begin
          fails++;
          $display("FAIL resp: got fault=%0b rdata=%h, expected fault=%0b rdata=%h",
                   resp_fault, resp_rdata, e.fault, e.rdata);
        end
      end
    end else if (rst_n) begin
      checks++;
      if (resp_rdata !== 32'h0 || resp_fault !== 1'b0) begin
        fails++;
        $display("FAIL idle_resp: rdata=%h fault=%0b, expected 0/0", resp_rdata, resp_fault);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    ram[idx]    = v;
    shadow[idx] = v;
  endtask

  // Drive one request, push expectation, check latency, busy and write count
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    int n, lat, exp_lat, wr0, exp_wr;
    exp_t e;
    logic [31:0] src;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    checks++;
    if (!req_ready) begin
      fails++;
      $display("FAIL ready_timeout: req_ready=%0b, expected 1", req_ready);
    end
    req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    e.fault = exp_fault(w, s, a);
    src     = a[10] ? shadow[a[9:2]] : rom_word(a);
    e.rdata = (!e.fault && !w) ? exp_load(src, s, u, a) : 32'h0;
    if (!e.fault && w) shadow[a[9:2]] = exp_merge(src, s, a, wd);
    sb.push_back(e);
    exp_lat = e.fault ? 1 : (!w ? 3 : (s == 2'b10 ? 2 : 4));
    exp_wr  = (!e.fault && w) ? 1 : 0;
    wr0 = wr_cnt;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      checks++;
      if (req_ready !== 1'b0) begin
        fails++;
        $display("FAIL busy_ready: req_ready=%0b at cycle %0d, expected 0", req_ready, lat);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat != exp_lat || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL latency: resp at cycle %0d ready=%0b, expected cycle %0d ready=0",
               lat, req_ready, exp_lat);
    end
    tick();
    checks++;
    if (wr_cnt - wr0 != exp_wr) begin
      fails++;
      $display("FAIL write_count: got %0d write cycles, expected %0d", wr_cnt - wr0, exp_wr);
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (req_ready !== 0 || resp_valid !== 0 || resp_rdata !== 0 || resp_fault !== 0 ||
        mem_address !== 0 || mem_read_write !== 0 || mem_wdata !== 0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%0b rv=%0b addr=%h rw=%0b, expected all 0",
               req_ready, resp_valid, mem_address, mem_read_write);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %0b, expected 1", req_ready);
    end
  endtask

  task automatic test_load_ext();
    set_word(0, 32'h8070_60F0);
    issue(0, 2'b00, 0, 32'h400, 0);  // -> FFFF_FFF0
    issue(0, 2'b01, 1, 32'h402, 0);  // -> 0000_8070
    issue(0, 2'b01, 0, 32'h402, 0);  // -> FFFF_8070
    issue(0, 2'b00, 1, 32'h403, 0);  // -> 0000_0080
    issue(0, 2'b00, 0, 32'h401, 0);  // -> 0000_0060
    issue(0, 2'b10, 0, 32'h014, 0);  // ROM word read
  endtask

  task automatic test_store_byte();
    set_word(0, 32'h1122_3344);
    issue(1, 2'b00, 0, 32'h401, 32'hFFFF_FFAB);
    checks++;
    if (ram[0] !== 32'h1122_AB44) begin
      fails++;
      $display("FAIL store_byte: word=%h, expected 1122ab44", ram[0]);
    end
    issue(1, 2'b01, 0, 32'h402, 32'h0000_BEEF);
    checks++;
    if (ram[0] !== 32'hBEEF_AB44) begin
      fails++;
      $display("FAIL store_half: word=%h, expected beefab44", ram[0]);
    end
  endtask

  task automatic test_faults();
    issue(1, 2'b10, 0, 32'h004, 32'h1234_5678);  // store to ROM
    issue(0, 2'b01, 0, 32'h403, 0);              // misaligned half
    issue(0, 2'b11, 0, 32'h400, 0);              // reserved size
    issue(0, 2'b10, 0, 32'h402, 0);              // misaligned word
    issue(1, 2'b00, 0, 32'h010, 32'h55);         // byte store to ROM
  endtask

  task automatic test_word_store_load();
    issue(1, 2'b10, 0, 32'h408, 32'hDEAD_BEEF);
    issue(0, 2'b10, 0, 32'h408, 0);
    checks++;
    if (ram[2] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL word_store: word=%h, expected deadbeef", ram[2]);
    end
  endtask

  task automatic test_reset_mid();
    int wr0;
    set_word(1, 32'h5566_7788);
    wr0 = wr_cnt;
    req_write = 1; req_size = 2'b00; req_unsigned = 0; req_addr = 32'h404; req_wdata = 32'h99;
    req_valid = 1'b1;
    tick();                 // ISSUE
    req_valid = 1'b0;
    tick();                 // WAIT
    checks++;
    if (mem_address !== 32'h404 || mem_read_write !== 1'b0) begin
      fails++;
      $display("FAIL wait_bus: addr=%h rw=%0b, expected 00000404/0", mem_address, mem_read_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 0 || resp_valid !== 0 || resp_rdata !== 0 || resp_fault !== 0 ||
        mem_address !== 0 || mem_read_write !== 0 || mem_wdata !== 0) begin
      fails++;
      $display("FAIL mid_reset_outputs: ready=%0b addr=%h rw=%0b wdata=%h, expected all 0",
               req_ready, mem_address, mem_read_write, mem_wdata);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_ready: got %0b, expected 1", req_ready);
    end
    tick(); tick(); tick();
    checks++;
    if (wr_cnt != wr0 || ram[1] !== 32'h5566_7788) begin
      fails++;
      $display("FAIL mid_reset_nowrite: writes=%0d word=%h, expected 0 and 55667788",
               wr_cnt - wr0, ram[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  s;
    for (int i = 0; i < 40; i++) begin
      a = {21'h0, ($urandom_range(0, 3) != 0), 4'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (s == 2'b01) a[0] = ($urandom_range(0, 4) == 0);
      if (s == 2'b10) a[1:0] = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00;
      issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) set_word(i, 32'hA5A5_0000 | i);
    test_reset();
    test_load_ext();
    test_store_byte();
    test_faults();
    test_word_store_load();
    test_reset_mid();
    test_back_to_back();
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== shadow[i]) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ram_contents: %0d words differ, expected 0", bad);
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses missing, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
